// File: rtl/ledr_pwm_driver_if.sv
// Avalon-MM control port of the LEDR PWM driver: zero-wait writes and
// combinational readdata, same bus style as the PIO slaves.
`timescale 1ns/1ps

interface ledr_pwm_driver_if;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address,
      output chipselect,
      output write_n,
      output writedata,
      input  readdata
   );

   modport slave (
      input  address,
      input  chipselect,
      input  write_n,
      input  writedata,
      output readdata
   );
endinterface

// File: rtl/ledr_pwm_driver.sv
// LEDR pin driver: frame-latched pattern and PWM duty, optional blink and
// polarity inversion. Define LEDR_PWM_GAMMA_EN for a squared duty mapping.
`timescale 1ns/1ps

module ledr_pwm_driver #(
   parameter int NUM_LEDS   = 10,
   parameter int PWM_BITS   = 8,
   parameter int BLINK_BITS = 16
) (
   input  logic                clk,
   input  logic                reset_n,
   ledr_pwm_driver_if.slave    bus,
   input  logic [NUM_LEDS-1:0] pattern_in,
   output logic [NUM_LEDS-1:0] ledr
);

   typedef enum logic [1:0] {
      REG_CTRL   = 2'd0,
      REG_DUTY   = 2'd1,
      REG_BLINK  = 2'd2,
      REG_STATUS = 2'd3
   } reg_addr_e;

   typedef struct packed {
      logic invert;
      logic blink_en;
      logic enable;
   } ctrl_t;

   localparam logic [PWM_BITS-1:0]   CNT_ONE  = PWM_BITS'(1);
   localparam logic [PWM_BITS-1:0]   CNT_LAST = '1;
   localparam logic [BLINK_BITS-1:0] FCNT_ONE = BLINK_BITS'(1);

   // Software-visible registers
   ctrl_t                 ctrl;
   logic [PWM_BITS-1:0]   duty;
   logic [BLINK_BITS-1:0] blink_half;

   // Frame-domain state
   logic                  enable_q;
   logic [PWM_BITS-1:0]   cnt;
   logic [PWM_BITS-1:0]   duty_act;
   logic [NUM_LEDS-1:0]   pat_act;
   logic [BLINK_BITS-1:0] fcnt;
   logic                  blink_phase;

   logic                  wr_en;
   reg_addr_e             addr;
   logic                  boundary;
   logic [PWM_BITS-1:0]   duty_mapped;
   logic [BLINK_BITS-1:0] half_m1;
   logic                  on;

   assign wr_en = bus.chipselect & ~bus.write_n;
   assign addr  = reg_addr_e'(bus.address);

   // ------------------------------------------------------------------
   // Control register file
   // ------------------------------------------------------------------
   // NOTE: state is updated with non-blocking assignments so every flop in
   // the design samples the pre-edge value of every other flop.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ctrl       <= '0;
         duty       <= '0;
         blink_half <= '0;
      end else if (wr_en) begin
         unique case (addr)
            REG_CTRL:   ctrl       <= ctrl_t'(bus.writedata[2:0]);
            REG_DUTY:   duty       <= bus.writedata[PWM_BITS-1:0];
            REG_BLINK:  blink_half <= bus.writedata[BLINK_BITS-1:0];
            REG_STATUS: ;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Read decode
   // ------------------------------------------------------------------
   // NOTE: readdata gets a full default before the case so no bit of it can
   // hold its value between evaluations, which would infer a latch.
   always_comb begin
      bus.readdata = '0;
      unique case (addr)
         REG_CTRL:   bus.readdata[2:0]            = ctrl;
         REG_DUTY:   bus.readdata[PWM_BITS-1:0]   = duty;
         REG_BLINK:  bus.readdata[BLINK_BITS-1:0] = blink_half;
         REG_STATUS: begin
            bus.readdata[0]              = blink_phase;
            bus.readdata[1]              = ctrl.enable;
            bus.readdata[PWM_BITS+7:8]   = duty_act;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Duty mapping applied when the shadow duty is latched
   // ------------------------------------------------------------------
`ifdef LEDR_PWM_GAMMA_EN
   logic [2*PWM_BITS-1:0] duty_sq;

   assign duty_sq     = {{PWM_BITS{1'b0}}, duty} * {{PWM_BITS{1'b0}}, duty};
   assign duty_mapped = duty_sq[2*PWM_BITS-1:PWM_BITS];
`else
   assign duty_mapped = duty;
`endif

   // ------------------------------------------------------------------
   // PWM frame counter and frame-boundary latching
   // ------------------------------------------------------------------
   // A boundary also fires on the first edge after enable rises, so the
   // first frame starts from a freshly latched pattern and duty.
   assign boundary = ctrl.enable & (~enable_q | (cnt == CNT_LAST));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         enable_q <= 1'b0;
         cnt      <= '0;
         duty_act <= '0;
         pat_act  <= '0;
      end else begin
         enable_q <= ctrl.enable;
         if (!ctrl.enable) begin
            cnt      <= '0;
            duty_act <= '0;
            pat_act  <= '0;
         end else if (boundary) begin
            cnt      <= '0;
            duty_act <= duty_mapped;
            pat_act  <= pattern_in;
         end else begin
            cnt      <= cnt + CNT_ONE;
         end
      end
   end

   // ------------------------------------------------------------------
   // Blink phase, advanced once per frame
   // ------------------------------------------------------------------
   // A half-period of zero is treated as one frame.
   assign half_m1 = (blink_half == '0) ? '0 : blink_half - FCNT_ONE;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fcnt        <= '0;
         blink_phase <= 1'b1;
      end else if (!ctrl.enable || !ctrl.blink_en) begin
         fcnt        <= '0;
         blink_phase <= 1'b1;
      end else if (boundary) begin
         if (fcnt >= half_m1) begin
            fcnt        <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            fcnt        <= fcnt + FCNT_ONE;
         end
      end
   end

   // ------------------------------------------------------------------
   // Registered pin drive
   // ------------------------------------------------------------------
   assign on = ctrl.enable & (cnt < duty_act) & (blink_phase | ~ctrl.blink_en);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ledr <= '0;
      end else begin
         ledr <= ({NUM_LEDS{on}} & pat_act) ^ {NUM_LEDS{ctrl.invert}};
      end
   end

endmodule
